// File: rtl/stream_max_finder.sv
// Streaming maximum finder: collects a burst of len unsigned samples and reports the largest
// value together with the index of its first occurrence, held until the consumer takes it.
module stream_max_finder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_max,
    output logic [LEN_W-1:0] out_idx,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        st_idle    = 2'd0,
        st_collect = 2'd1,
        st_done    = 2'd2
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;

    // Flags are registered alongside the state so they are pure state decodes with no
    // combinational path from any input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= st_idle;
            len_q     <= '0;
            cnt       <= '0;
            out_max   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                st_idle: begin
                    if (start && (len != '0)) begin
                        len_q    <= len;
                        cnt      <= '0;
                        state    <= st_collect;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                st_collect: begin
                    if (in_valid) begin
                        // First beat loads unconditionally; later beats only on a strict win.
                        if ((cnt == '0) || (in_data > out_max)) begin
                            out_max <= in_data;
                            out_idx <= cnt;
                        end
                        if (cnt == len_q - 1'b1) begin
                            state     <= st_done;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                st_done: begin
                    if (out_ready) begin
                        state     <= st_idle;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= st_idle;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_max_finder.sv
// Self-checking bench for stream_max_finder: directed table, hand-written corner sequences and
// randomized bursts checked against a simple max/first-index model.
module tb_stream_max_finder;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_max;
    logic [LEN_W-1:0] out_idx;
    logic             out_ready;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] smp[$];

    typedef struct {
        int              len;
        logic [15*8-1:0] data;
        logic [7:0]      emax;
        logic [3:0]      eidx;
        int              maxgap;
    } vec_t;

    vec_t tbl[6];

    stream_max_finder #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_max  (out_max),
        .out_idx  (out_idx),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: largest value, then the lowest index holding it.
    task automatic model(input int n, output logic [7:0] m, output logic [3:0] idx);
        m = 0;
        for (int i = 0; i < n; i++) if (smp[i] > m) m = smp[i];
        idx = 0;
        for (int i = n - 1; i >= 0; i--) if (smp[i] == m) idx = 4'(i);
    endtask

    // Runs one burst from IDLE using smp[0..n-1]; leaves the result un-acknowledged.
    task automatic collect(input int n, input int maxgap);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("in_ready_after_start", 32'(in_ready), 1);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            for (int g = 0; g < gap; g++) tick();
            in_valid = 1'b1;
            in_data  = smp[i];
            tick();
            if (i == n - 2) chk("out_valid_early", 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        chk("out_valid_latency", 32'(out_valid), 1);
        chk("in_ready_in_done", 32'(in_ready), 0);
    endtask

    task automatic handshake(input logic [7:0] emax, input logic [3:0] eidx);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(out_valid), 0);
        chk("busy_after_hs", 32'(busy), 0);
        chk("max_retained", 32'(out_max), 32'(emax));
        chk("idx_retained", 32'(out_idx), 32'(eidx));
    endtask

    initial begin
        logic [7:0] m;
        logic [3:0] ix;

        // Directed table: len=3 rising, tie keeps first, len=1 zero, len=15 max last.
        tbl[0] = '{3, 120'h00_0000_0000_0000_0000_0000_0000_1e140a, 8'd30, 4'd2, 0};
        tbl[1] = '{3, 120'h00_0000_0000_0000_0000_0000_0000_051414, 8'd20, 4'd0, 0};
        tbl[2] = '{1, '0, 8'd0, 4'd0, 0};
        tbl[3] = '{15, '0, 8'd255, 4'd14, 0};
        for (int i = 0; i < 14; i++) tbl[3].data[i*8+:8] = 8'd7;
        tbl[3].data[14*8+:8] = 8'd255;
        tbl[4] = '{5, 120'h00_0000_0000_0000_0000_0000_0005_0905_0302, 8'd9, 4'd3, 3};
        tbl[5] = '{4, 120'h00_0000_0000_0000_0000_0000_0000_2a2a_2a2a, 8'd42, 4'd0, 2};

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_max", 32'(out_max), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) begin
            smp.delete();
            for (int i = 0; i < tbl[t].len; i++) smp.push_back(tbl[t].data[i*8+:8]);
            collect(tbl[t].len, tbl[t].maxgap);
            chk($sformatf("tbl%0d_max", t), 32'(out_max), 32'(tbl[t].emax));
            chk($sformatf("tbl%0d_idx", t), 32'(out_idx), 32'(tbl[t].eidx));
            handshake(tbl[t].emax, tbl[t].eidx);
        end

        // Result held under back-pressure while start pulses; start on handshake ignored.
        smp = '{8'd4, 8'd99, 8'd17};
        collect(3, 0);
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            len   = 4'd3;
            tick();
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_max", 32'(out_max), 99);
            chk("hold_idx", 32'(out_idx), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_busy", 32'(busy), 1);
        end
        start = 1'b1;
        handshake(8'd99, 4'd1);
        start = 1'b0;
        tick();
        chk("start_on_hs_ignored", 32'(busy), 0);

        // len=0 start is ignored.
        start = 1'b1; len = '0;
        tick();
        start = 1'b0;
        chk("len0_busy", 32'(busy), 0);
        chk("len0_in_ready", 32'(in_ready), 0);
        chk("len0_max_kept", 32'(out_max), 99);
        tick();
        chk("len0_busy_later", 32'(busy), 0);

        // Asynchronous abort mid-burst, then a fresh burst right after release.
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'd200; tick();
        in_data = 8'd201; tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_max", 32'(out_max), 0);
        chk("abort_idx", 32'(out_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        smp = '{8'd9, 8'd3};
        collect(2, 0);
        chk("post_rst_max", 32'(out_max), 9);
        chk("post_rst_idx", 32'(out_idx), 0);
        handshake(8'd9, 4'd0);

        // Randomized bursts against the model; narrow value ranges provoke ties.
        for (int r = 0; r < 30; r++) begin
            int n;
            int hi;
            n  = int'($urandom_range(1, 15));
            hi = (r % 2 == 0) ? 7 : 255;
            smp.delete();
            for (int i = 0; i < n; i++) smp.push_back(8'($urandom_range(0, hi)));
            model(n, m, ix);
            collect(n, 3);
            chk($sformatf("rnd%0d_max", r), 32'(out_max), 32'(m));
            chk($sformatf("rnd%0d_idx", r), 32'(out_idx), 32'(ix));
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) tick();
            handshake(m, ix);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
